// File: rtl/pipe_stage_reg.sv
// Pipeline stage register between two CPU stages: PC, NUM_FIELDS data fields and a
// delay-slot flag behind a valid/ready handshake, with optional skid entry, flush and stall counter.
module pipe_stage_reg #(
    parameter int DATA_W           = 32,
    parameter int NUM_FIELDS       = 4,
    parameter int SKID             = 1,
    parameter int KEEP_PC_ON_FLUSH = 1,
    parameter int CNT_W            = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_pc,
    input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
    input  logic                         in_bd,
    input  logic                         flush,
    input  logic [31:0]                  flush_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_pc,
    output logic [NUM_FIELDS*DATA_W-1:0] out_data,
    output logic                         out_bd,
    output logic [CNT_W-1:0]             stall_cnt
);

    localparam int PW = NUM_FIELDS * DATA_W;

    logic             r_m_valid;
    logic [31:0]      r_m_pc;
    logic [PW-1:0]    r_m_data;
    logic             r_m_bd;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_accept;
    logic             w_release;
    logic [31:0]      w_bubble_pc;

    assign w_accept    = in_valid && in_ready;
    assign w_release   = r_m_valid && out_ready;
    assign w_bubble_pc = (KEEP_PC_ON_FLUSH != 0) ? flush_pc : 32'd0;

    generate
        if (SKID != 0) begin : g_skid
            logic          r_s_valid;
            logic [31:0]   r_s_pc;
            logic [PW-1:0] r_s_data;
            logic          r_s_bd;

            // in_ready is a flop output: only the skid entry's occupancy gates it
            assign in_ready = !r_s_valid;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_m_valid <= 1'b0;
                    r_m_pc    <= '0;
                    r_m_data  <= '0;
                    r_m_bd    <= 1'b0;
                    r_s_valid <= 1'b0;
                    r_s_pc    <= '0;
                    r_s_data  <= '0;
                    r_s_bd    <= 1'b0;
                end else if (flush) begin
                    r_m_valid <= 1'b0;
                    r_s_valid <= 1'b0;
                    r_m_pc    <= w_bubble_pc;
                    r_m_data  <= '0;
                    r_m_bd    <= 1'b0;
                end else if (r_s_valid) begin
                    if (w_release) begin
                        r_m_pc    <= r_s_pc;
                        r_m_data  <= r_s_data;
                        r_m_bd    <= r_s_bd;
                        r_s_valid <= 1'b0;
                    end
                end else if (w_accept && r_m_valid && !w_release) begin
                    // M is stuck: park the new item behind it
                    r_s_pc    <= in_pc;
                    r_s_data  <= in_data;
                    r_s_bd    <= in_bd;
                    r_s_valid <= 1'b1;
                end else if (w_accept) begin
                    r_m_pc    <= in_pc;
                    r_m_data  <= in_data;
                    r_m_bd    <= in_bd;
                    r_m_valid <= 1'b1;
                end else if (w_release) begin
                    r_m_valid <= 1'b0;
                end
            end
        end else begin : g_single
            assign in_ready = !r_m_valid || out_ready;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_m_valid <= 1'b0;
                    r_m_pc    <= '0;
                    r_m_data  <= '0;
                    r_m_bd    <= 1'b0;
                end else if (flush) begin
                    r_m_valid <= 1'b0;
                    r_m_pc    <= w_bubble_pc;
                    r_m_data  <= '0;
                    r_m_bd    <= 1'b0;
                end else if (w_accept) begin
                    r_m_pc    <= in_pc;
                    r_m_data  <= in_data;
                    r_m_bd    <= in_bd;
                    r_m_valid <= 1'b1;
                end else if (w_release) begin
                    r_m_valid <= 1'b0;
                end
            end
        end
    endgenerate

    // Counts stalled cycles even while flushing; only reset clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (r_m_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_m_valid;
    assign out_pc    = r_m_pc;
    assign out_data  = r_m_data;
    assign out_bd    = r_m_bd;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three configurations share one input stream, each checked
// every cycle against a queue-based reference model, plus directed literal checks.
module tb_pipe_stage_reg;

    localparam int DW = 128;

    typedef struct packed {
        logic [31:0]   pc;
        logic [DW-1:0] data;
        logic          bd;
    } item_t;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_bd, flush;
    logic [31:0]   in_pc, flush_pc;
    logic [DW-1:0] in_data;
    logic [2:0]    ordy, irdy, ovld, obd;
    logic [2:0][31:0]   opc;
    logic [2:0][DW-1:0] odata;
    logic [15:0]   cnt0;
    logic [3:0]    cnt1, cnt2;
    logic [2:0][15:0] cw;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    assign cw[0] = cnt0;
    assign cw[1] = {12'd0, cnt1};
    assign cw[2] = {12'd0, cnt2};

    // u0: skid, keep pc; u1: single entry, zero pc, 4-bit cnt; u2: skid, zero pc, 4-bit cnt
    pipe_stage_reg #(.DATA_W(32), .NUM_FIELDS(4), .SKID(1), .KEEP_PC_ON_FLUSH(1), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(irdy[0]), .in_pc(in_pc),
        .in_data(in_data), .in_bd(in_bd), .flush(flush), .flush_pc(flush_pc),
        .out_valid(ovld[0]), .out_ready(ordy[0]), .out_pc(opc[0]), .out_data(odata[0]),
        .out_bd(obd[0]), .stall_cnt(cnt0));
    pipe_stage_reg #(.DATA_W(32), .NUM_FIELDS(4), .SKID(0), .KEEP_PC_ON_FLUSH(0), .CNT_W(4)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(irdy[1]), .in_pc(in_pc),
        .in_data(in_data), .in_bd(in_bd), .flush(flush), .flush_pc(flush_pc),
        .out_valid(ovld[1]), .out_ready(ordy[1]), .out_pc(opc[1]), .out_data(odata[1]),
        .out_bd(obd[1]), .stall_cnt(cnt1));
    pipe_stage_reg #(.DATA_W(32), .NUM_FIELDS(4), .SKID(1), .KEEP_PC_ON_FLUSH(0), .CNT_W(4)) u2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(irdy[2]), .in_pc(in_pc),
        .in_data(in_data), .in_bd(in_bd), .flush(flush), .flush_pc(flush_pc),
        .out_valid(ovld[2]), .out_ready(ordy[2]), .out_pc(opc[2]), .out_data(odata[2]),
        .out_bd(obd[2]), .stall_cnt(cnt2));

    // Reference model: an ordered list of held items (capacity 2 with skid, 1 without)
    item_t       mq [3][2];
    int          mn [3];
    item_t       mh [3];
    int unsigned mc [3];
    bit          model_ok = 1'b0;

    function automatic bit sk(int d);   return d != 1; endfunction
    function automatic bit kp(int d);   return d == 0; endfunction
    function automatic int unsigned cmax(int d); return (d == 0) ? 65535 : 15; endfunction

    function automatic bit m_irdy(int d);
        if (sk(d)) return mn[d] < 2;
        return (mn[d] == 0) || ordy[d];
    endfunction

    function automatic item_t m_out(int d);
        return (mn[d] > 0) ? mq[d][0] : mh[d];
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                mn[d] = 0;
                mh[d] = '0;
                mc[d] = 0;
            end else begin
                automatic bit rel = (mn[d] > 0) && ordy[d];
                automatic bit acc = in_valid && m_irdy(d);
                if (mn[d] > 0 && !ordy[d] && mc[d] < cmax(d)) mc[d] = mc[d] + 1;
                if (flush) begin
                    mn[d] = 0;
                    mh[d] = '0;
                    mh[d].pc = kp(d) ? flush_pc : 32'd0;
                end else begin
                    if (rel) begin
                        mh[d] = mq[d][0];
                        mq[d][0] = mq[d][1];
                        mn[d] = mn[d] - 1;
                    end
                    if (acc) begin
                        mq[d][mn[d]] = '{pc: in_pc, data: in_data, bd: in_bd};
                        mn[d] = mn[d] + 1;
                    end
                end
            end
        end
        if (reset) model_ok = 1'b1;
    end

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            for (int d = 0; d < 3; d++) begin
                automatic item_t e = m_out(d);
                chk($sformatf("d%0d in_ready", d),  DW'(irdy[d]), DW'(m_irdy(d)));
                chk($sformatf("d%0d out_valid", d), DW'(ovld[d]), DW'(mn[d] > 0));
                chk($sformatf("d%0d out_pc", d),    DW'(opc[d]),  DW'(e.pc));
                chk($sformatf("d%0d out_data", d),  odata[d],     e.data);
                chk($sformatf("d%0d out_bd", d),    DW'(obd[d]),  DW'(e.bd));
                chk($sformatf("d%0d stall_cnt", d), DW'(cw[d]),   DW'(mc[d]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_bd = 1'b0; flush = 1'b0;
        in_pc = '0; flush_pc = '0; in_data = '0; ordy = 3'b000;
        cyc(); cyc();
        reset = 1'b0;
        chk("rst out_pc", DW'(opc[0]), DW'(0));
        chk("rst stall_cnt", DW'(cnt0), DW'(0));
        chk("rst in_ready", DW'(irdy), DW'(3'b111));
        chk("rst out_valid", DW'(ovld), DW'(0));
        chk("rst out_data", odata[0], '0);

        // Streaming at full rate
        ordy = 3'b111; in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_pc = 32'h3000 + 32'(4 * k);
            in_data = {4{32'(k)}};
            cyc();
            chk("stream out_pc", DW'(opc[0]), DW'(32'h3000 + 32'(4 * k)));
            chk("stream in_ready", DW'(irdy[0]), DW'(1));
        end
        in_valid = 1'b0;
        cyc(); cyc();

        // Backpressure with two items
        in_valid = 1'b1; in_pc = 32'h3000; ordy = 3'b000;
        cyc();
        in_pc = 32'h3004;
        cyc();
        in_valid = 1'b0;
        cyc(); cyc();
        chk("bp stall_cnt", DW'(cnt0), DW'(3));
        chk("bp in_ready", DW'(irdy[0]), DW'(0));
        chk("bp head A", DW'(opc[0]), DW'(32'h3000));
        ordy = 3'b111;
        cyc();
        chk("bp then B", DW'(opc[0]), DW'(32'h3004));
        chk("bp B valid", DW'(ovld[0]), DW'(1));
        chk("bp cnt held", DW'(cnt0), DW'(3));
        cyc();
        chk("bp drained", DW'(ovld[0]), DW'(0));
        chk("bp pc hold", DW'(opc[0]), DW'(32'h3004));

        // Flush bubble over a delay-slot item
        in_valid = 1'b1; in_pc = 32'h3008; in_bd = 1'b1; in_data = {4{32'hA5A5_5A5A}}; ordy = 3'b000;
        cyc();
        in_valid = 1'b0; in_bd = 1'b0;
        chk("fl held bd", DW'(obd[0]), DW'(1));
        flush = 1'b1; flush_pc = 32'h3008;
        cyc();
        flush = 1'b0;
        chk("fl out_valid", DW'(ovld[0]), DW'(0));
        chk("fl out_data", odata[0], '0);
        chk("fl out_bd", DW'(obd[0]), DW'(0));
        chk("fl keep pc", DW'(opc[0]), DW'(32'h3008));
        chk("fl zero pc", DW'(opc[2]), DW'(0));
        chk("fl in_ready", DW'(irdy[0]), DW'(1));

        // Flush while full, with an item offered in the same cycle
        in_valid = 1'b1; in_pc = 32'h5000;
        cyc();
        in_pc = 32'h5004;
        cyc();
        in_pc = 32'h5008; flush = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl2 out_valid", DW'(ovld), DW'(0));
        chk("fl2 in_ready", DW'(irdy[0]), DW'(1));
        ordy = 3'b111;
        cyc();
        chk("fl2 nothing left", DW'(ovld), DW'(0));

        // Single-entry: combinational in_ready and replacement on release
        ordy = 3'b000; in_valid = 1'b1; in_pc = 32'h4000;
        cyc();
        chk("s0 held", DW'(opc[1]), DW'(32'h4000));
        chk("s0 not ready", DW'(irdy[1]), DW'(0));
        ordy = 3'b010; in_pc = 32'h4004;
        #1;
        chk("s0 ready comb", DW'(irdy[1]), DW'(1));
        cyc();
        chk("s0 replaced", DW'(opc[1]), DW'(32'h4004));
        chk("s0 valid", DW'(ovld[1]), DW'(1));

        // Saturate 4-bit counters, then reset together with flush
        ordy = 3'b000;
        repeat (20) cyc();
        chk("sat cnt1", DW'(cnt1), DW'(15));
        chk("sat cnt2", DW'(cnt2), DW'(15));
        reset = 1'b1; flush = 1'b1; flush_pc = 32'hDEAD_BEEF;
        cyc();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        chk("rr out_valid", DW'(ovld), DW'(0));
        chk("rr out_pc", DW'(opc), DW'(0));
        chk("rr cnt", DW'({cnt0, cnt1, cnt2}), DW'(0));
        chk("rr in_ready", DW'(irdy), DW'(3'b111));
        chk("rr out_data", odata[0], '0);

        // Random traffic
        repeat (3000) begin
            reset    = ($urandom_range(0, 199) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            ordy     = 3'($urandom_range(0, 7));
            in_pc    = $urandom;
            flush_pc = $urandom;
            in_bd    = 1'($urandom);
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            cyc();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
